lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
- Controller that sequences the HD44780-style LCD send FSM (RS/RW/data/enable-pulse engine).
- After reset it runs the LCD power-up init command sequence with the required execution delays.
- It then serves three host request types, one transaction at a time, with fixed priority: clear display, set cursor position, write character.
- It sits between the host-side display logic (DMX value/channel readout) and the send FSM. It owns the dataReady/dataDone handshake and all inter-command timing.

Parameters:
- POWERUP_CYCLES, 720000: idle cycles after reset before the first init command (15 ms at 48 MHz).
- CMD_WAIT_CYCLES, 2000: post-command delay for normal commands and character writes (>37 us at 48 MHz).
- CLEAR_WAIT_CYCLES, 80000: post-command delay after 0x01 clear or 0x02 home (>1.52 ms at 48 MHz).

Ports:
- int_osc  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- clr_req  in  1  request clear display; held high until clr_ack.
- clr_ack  out  1  one-cycle pulse: clear accepted.
- pos_req  in  1  request DDRAM address set; held high until pos_ack.
- pos_addr  in  7  DDRAM address; sampled on acceptance.
- pos_ack  out  1  one-cycle pulse: position accepted.
- wr_req  in  1  request character write; held high until wr_ack.
- wr_char  in  8  character code; sampled on acceptance.
- wr_ack  out  1  one-cycle pulse: write accepted.
- busy  out  1  high whenever state is not IDLE.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- dataReady  out  1  to send FSM: one-cycle start pulse.
- RS  out  1  to send FSM RSin.
- RW  out  1  to send FSM RWin; always 0 (write-only).
- dataOut  out  8  to send FSM dataIn.
- dataDone  in  1  from send FSM: one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Next state is PWR_WAIT and the delay counter loads POWERUP_CYCLES.
  - Init index clears to 0.
  - All outputs are 0: dataReady, RS, RW, dataOut, busy (until the next edge), init_done, and all acks.
  - Reset mid-transaction aborts it. The full power-up and init sequence reruns; no pending request is remembered.
- States: PWR_WAIT, INIT_SEND, IDLE, SEND, WAIT_DONE, DELAY.
- PWR_WAIT: lasts exactly POWERUP_CYCLES cycles, then goes to INIT_SEND.
- Init ROM, index 0..5: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. All are RS=0.
- INIT_SEND: registers RS=0 and dataOut=ROM[index], then goes to SEND.
- IDLE: samples requests at the clock edge with priority clr > pos > wr. Exactly one request is accepted per edge.
  - clr accepted: RS=0, dataOut=0x01.
  - pos accepted: RS=0, dataOut={1'b1,pos_addr}.
  - wr accepted: RS=1, dataOut=wr_char.
  - The accepting edge registers the RS/data values and moves to SEND.
- SEND: lasts one cycle. dataReady=1. The matching ack is 1 in this same cycle (acks are never asserted for init commands). Next state is WAIT_DONE.
- WAIT_DONE: dataReady=0. Waits indefinitely for dataDone. On the edge sampling dataDone=1, the counter loads CLEAR_WAIT_CYCLES if dataOut is 0x01 or 0x02, else CMD_WAIT_CYCLES, and the state moves to DELAY.
- DELAY: lasts exactly the loaded number of cycles.
  - During init: the index increments. Index 5 done → init_done=1, go to IDLE. Otherwise go to INIT_SEND.
  - After a host command: go to IDLE.
- RS, RW, dataOut are registered and stay stable from SEND through DELAY, until the next load. The send FSM passes data through combinationally, so this stability is mandatory.
- Requests asserted before init_done are not acked. They are served in IDLE once init_done=1.
- dataDone arriving outside WAIT_DONE is ignored.
- The send FSM en is tied high. If dataDone never arrives, the block stays in WAIT_DONE with busy=1; there is no timeout.
- Delay counter width is $clog2 of the largest parameter plus 1. It counts down with no wrap.

Test Plan:
- Power-up/init: POWERUP=20, CMD=5, CLEAR=10, send FSM model attached, release reset.
  - First dataReady comes 21 cycles after release.
  - Six dataReady pulses carry dataOut 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
  - Gap after 0x01 is 10 cycles; all other gaps are 5 cycles.
  - init_done rises after the last delay; no acks fire.
- Write: wr_req=1, wr_char=0x41 in IDLE.
  - Next cycle: wr_ack=1, dataReady=1, RS=1, dataOut=0x41.
  - RS/dataOut are held through dataDone plus 5 cycles; busy=0 afterwards.
- Priority: clr_req, pos_req (pos_addr=0x40), wr_req (0x5A) raised together and held until each ack.
  - Commands issue in order 0x01 (10-cycle delay), 0xC0, then 0x5A with RS=1.
  - Acks fire in order clr, pos, wr.
- Early request: wr_req asserted during PWR_WAIT.
  - No ack and no RS=1 transfer occur before init_done.
  - The write is issued as the first transaction after init.
- Stalled dataDone: send FSM model delays dataDone by 50 cycles.
  - Block stays in WAIT_DONE with busy=1, dataReady=0, and data stable.
  - The delay starts only after dataDone.
- Reset mid-DELAY of a clear:
  - Next cycle all outputs are 0 and init_done=0.
  - The init sequence restarts from 0x38 after POWERUP cycles.

Source files
------------

// File: rtl/lcd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_sequencer
//
// Purpose:
//   Command sequencer in front of an HD44780-style LCD send FSM. After reset it
//   waits out the LCD power-up time, then plays the six-entry init command ROM.
//   Once init completes it serves host requests one at a time with fixed
//   priority: clear display, then cursor position, then character write. It
//   owns the dataReady/dataDone handshake and every inter-command delay.
//
// Ports:
//   int_osc    in   1  system clock
//   reset      in   1  synchronous, active-low reset
//   clr_req    in   1  clear-display request, held until clr_ack
//   clr_ack    out  1  one-cycle pulse, clear accepted
//   pos_req    in   1  set-DDRAM-address request, held until pos_ack
//   pos_addr   in   7  DDRAM address, sampled on acceptance
//   pos_ack    out  1  one-cycle pulse, position accepted
//   wr_req     in   1  character-write request, held until wr_ack
//   wr_char    in   8  character code, sampled on acceptance
//   wr_ack     out  1  one-cycle pulse, write accepted
//   busy       out  1  high whenever the sequencer is not idle
//   init_done  out  1  high once the init sequence has completed
//   dataReady  out  1  one-cycle start pulse to the send FSM
//   RS         out  1  register select to the send FSM
//   RW         out  1  read/write to the send FSM, always write (0)
//   dataOut    out  8  command/data byte to the send FSM
//   dataDone   in   1  one-cycle completion pulse from the send FSM
//
// State table:
//   state        | meaning
//   S_PWR_WAIT   | power-up settling delay after reset
//   S_INIT_SEND  | load the next init ROM entry into RS/dataOut
//   S_IDLE       | init done, waiting for a host request
//   S_SEND       | dataReady (and host ack) pulse, one cycle
//   S_WAIT_DONE  | waiting for the send FSM to finish, no timeout
//   S_DELAY      | post-command execution delay
// -----------------------------------------------------------------------------
module lcd_sequencer #(
    parameter int POWERUP_CYCLES    = 720000,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 80000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       clr_req,
    output logic       clr_ack,
    input  logic       pos_req,
    input  logic [6:0] pos_addr,
    output logic       pos_ack,
    input  logic       wr_req,
    input  logic [7:0] wr_char,
    output logic       wr_ack,
    output logic       busy,
    output logic       init_done,
    output logic       dataReady,
    output logic       RS,
    output logic       RW,
    output logic [7:0] dataOut,
    input  logic       dataDone
);

    localparam int MAX_AB  = (POWERUP_CYCLES > CMD_WAIT_CYCLES) ? POWERUP_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > CLEAR_WAIT_CYCLES) ? MAX_AB : CLEAR_WAIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] C_PWR   = CNT_W'(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(CMD_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] C_CLEAR = CNT_W'(CLEAR_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO  = '0;

    localparam logic [2:0] LAST_INIT_IDX = 3'd5;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_SEND,
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_DELAY
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_init_done;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_busy;
    logic [2:0]       r_ack;      // {clr, pos, wr}

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_cnt_last;
    logic [2:0]       w_idx_nxt;
    logic             w_init_done_nxt;
    logic             w_rs_nxt;
    logic [7:0]       w_data_nxt;
    logic [2:0]       w_ack_nxt;
    logic             w_long_cmd;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0, 3'd1, 3'd2: v = 8'h38;  // function set, 8-bit, 2 lines
            3'd3:             v = 8'h0C;  // display on, cursor off
            3'd4:             v = 8'h01;  // clear display
            3'd5:             v = 8'h06;  // entry mode, increment
            default:          v = 8'h00;
        endcase
        return v;
    endfunction

    // Down-counter saturates at zero; a timed state ends on the cycle the
    // counter shows 1, so a load of N gives exactly N cycles in the state.
    assign w_cnt_dec  = (r_cnt != C_ZERO) ? (r_cnt - C_ONE) : C_ZERO;
    assign w_cnt_last = (r_cnt <= C_ONE);

    // Clear and home need the long execution time regardless of RS.
    assign w_long_cmd = (r_data == 8'h01) || (r_data == 8'h02);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_init_done_nxt = r_init_done;
        w_rs_nxt        = r_rs;
        w_data_nxt      = r_data;
        w_ack_nxt       = 3'b000;

        case (r_state)
            S_PWR_WAIT: begin
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_last) begin
                    w_state_nxt = S_INIT_SEND;
                end
            end

            S_INIT_SEND: begin
                w_rs_nxt    = 1'b0;
                w_data_nxt  = init_rom(r_idx);
                w_state_nxt = S_SEND;
            end

            S_IDLE: begin
                if (r_init_done) begin
                    if (clr_req) begin
                        w_rs_nxt    = 1'b0;
                        w_data_nxt  = 8'h01;
                        w_ack_nxt   = 3'b100;
                        w_state_nxt = S_SEND;
                    end else if (pos_req) begin
                        w_rs_nxt    = 1'b0;
                        w_data_nxt  = {1'b1, pos_addr};
                        w_ack_nxt   = 3'b010;
                        w_state_nxt = S_SEND;
                    end else if (wr_req) begin
                        w_rs_nxt    = 1'b1;
                        w_data_nxt  = wr_char;
                        w_ack_nxt   = 3'b001;
                        w_state_nxt = S_SEND;
                    end
                end
            end

            S_SEND: begin
                w_state_nxt = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (dataDone) begin
                    w_cnt_nxt   = w_long_cmd ? C_CLEAR : C_CMD;
                    w_state_nxt = S_DELAY;
                end
            end

            S_DELAY: begin
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_last) begin
                    if (r_init_done) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        if (r_idx == LAST_INIT_IDX) begin
                            w_init_done_nxt = 1'b1;
                            w_state_nxt     = S_IDLE;
                        end else begin
                            w_state_nxt = S_INIT_SEND;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_PWR_WAIT;
                w_cnt_nxt   = C_PWR;
            end
        endcase
    end

    // Outputs are registered from the next state so the send FSM, which is
    // combinational on RS/dataOut, only ever sees clean values.
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            r_state     <= S_PWR_WAIT;
            r_cnt       <= C_PWR;
            r_idx       <= 3'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_ack       <= 3'b000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_init_done <= w_init_done_nxt;
            r_rs        <= w_rs_nxt;
            r_data      <= w_data_nxt;
            r_ready     <= (w_state_nxt == S_SEND);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_ack       <= w_ack_nxt;
        end
    end

    assign clr_ack   = r_ack[2];
    assign pos_ack   = r_ack[1];
    assign wr_ack    = r_ack[0];
    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign dataReady = r_ready;
    assign RS        = r_rs;
    assign RW        = 1'b0;
    assign dataOut   = r_data;

endmodule

// File: tb/tb_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_sequencer
//
// Purpose:
//   Self-checking bench for lcd_sequencer. The bench plays both the host and
//   the send FSM. Expected transfers come from the init command list and from
//   the priority rule applied to the set of pending requests; expected delays
//   come from the command byte (0x01/0x02 long, everything else short).
// -----------------------------------------------------------------------------
module tb_lcd_sequencer;

    localparam int PWR = 20;
    localparam int CMD = 5;
    localparam int CLR = 10;

    logic       int_osc = 1'b0;
    logic       reset   = 1'b0;
    logic       clr_req = 1'b0;
    logic       pos_req = 1'b0;
    logic       wr_req  = 1'b0;
    logic [6:0] pos_addr = 7'd0;
    logic [7:0] wr_char  = 8'd0;
    logic       dataDone = 1'b0;

    logic       clr_ack, pos_ack, wr_ack, busy, init_done, dataReady, RS, RW;
    logic [7:0] dataOut;

    int total = 0;
    int bad   = 0;

    logic [7:0] init_cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_sequencer #(
        .POWERUP_CYCLES    (PWR),
        .CMD_WAIT_CYCLES   (CMD),
        .CLEAR_WAIT_CYCLES (CLR)
    ) dut (
        .int_osc   (int_osc),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_ack   (clr_ack),
        .pos_req   (pos_req),
        .pos_addr  (pos_addr),
        .pos_ack   (pos_ack),
        .wr_req    (wr_req),
        .wr_char   (wr_char),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .init_done (init_done),
        .dataReady (dataReady),
        .RS        (RS),
        .RW        (RW),
        .dataOut   (dataOut),
        .dataDone  (dataDone)
    );

    always #5 int_osc = ~int_osc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic step();
        @(negedge int_osc);
    endtask

    function automatic logic [2:0] acks();
        return {clr_ack, pos_ack, wr_ack};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(dataReady), 32'(0));
        chk({tag, "_rs"},     32'(RS),        32'(0));
        chk({tag, "_rw"},     32'(RW),        32'(0));
        chk({tag, "_data"},   32'(dataOut),   32'(0));
        chk({tag, "_busy"},   32'(busy),      32'(0));
        chk({tag, "_idone"},  32'(init_done), 32'(0));
        chk({tag, "_acks"},   32'(acks()),    32'(0));
    endtask

    // One full transfer as seen by the send FSM: wait for dataReady, check the
    // transfer, answer dataDone after lat cycles, then watch the delay.
    // Returns at the first cycle after the delay, or early inside the delay
    // at index abort_at when abort_at >= 0.
    task automatic run_xact(input string tag, input int exp_gap, input logic exp_rs,
                            input logic [7:0] exp_d, input logic [2:0] exp_ack,
                            input int lat, input logic exp_busy_after, input int abort_at);
        int  n;
        int  wait_n;
        bit  ok;
        n = 0;
        while (dataReady !== 1'b1 && n < exp_gap + 60) begin
            step();
            n++;
        end
        if (dataReady !== 1'b1) begin
            chk({tag, "_timeout"}, 32'(dataReady), 32'(1));
            finish_up();
        end
        chk({tag, "_gap"},  32'(n),       32'(exp_gap));
        chk({tag, "_rs"},   32'(RS),      32'(exp_rs));
        chk({tag, "_data"}, 32'(dataOut), 32'(exp_d));
        chk({tag, "_rw"},   32'(RW),      32'(0));
        chk({tag, "_ack"},  32'(acks()),  32'(exp_ack));
        chk({tag, "_busy"}, 32'(busy),    32'(1));
        if (clr_ack) clr_req = 1'b0;
        if (pos_ack) pos_req = 1'b0;
        if (wr_ack)  wr_req  = 1'b0;

        ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            step();
            if (dataReady !== 1'b0 || busy !== 1'b1 || RS !== exp_rs ||
                dataOut !== exp_d || acks() !== 3'b000) ok = 1'b0;
        end
        chk({tag, "_hold_wait"}, 32'(ok), 32'(1));

        dataDone = 1'b1;
        step();
        dataDone = 1'b0;

        wait_n = (exp_d == 8'h01 || exp_d == 8'h02) ? CLR : CMD;
        ok = 1'b1;
        for (int k = 0; k < wait_n; k++) begin
            if (k == abort_at) begin
                chk({tag, "_hold_delay"}, 32'(ok), 32'(1));
                return;
            end
            if (dataReady !== 1'b0 || busy !== 1'b1 || RS !== exp_rs ||
                dataOut !== exp_d || acks() !== 3'b000) ok = 1'b0;
            step();
        end
        chk({tag, "_hold_delay"}, 32'(ok), 32'(1));
        chk({tag, "_busy_after"}, 32'(busy), 32'(exp_busy_after));
    endtask

    // Call right at reset release: first command expected PWR+1 cycles later.
    task automatic run_init(input string tag);
        for (int i = 0; i < 6; i++) begin
            run_xact($sformatf("%s_init%0d", tag, i), (i == 0) ? PWR + 1 : 1, 1'b0,
                     init_cmds[i], 3'b000, $urandom_range(1, 4), (i != 5), -1);
            chk($sformatf("%s_idone%0d", tag, i), 32'(init_done), 32'(i == 5));
        end
    endtask

    // Raise a random subset of requests together; expected service order is
    // the fixed priority clr > pos > wr.
    task automatic host_batch(input string tag, input logic [2:0] mask, input int lat_max);
        logic [6:0] a;
        logic [7:0] c;
        a = 7'($urandom_range(0, 127));
        c = 8'($urandom_range(0, 255));
        pos_addr = a;
        wr_char  = c;
        clr_req  = mask[2];
        pos_req  = mask[1];
        wr_req   = mask[0];
        if (mask[2]) run_xact({tag, "_clr"}, 1, 1'b0, 8'h01, 3'b100,
                              $urandom_range(1, lat_max), 1'b0, -1);
        if (mask[1]) run_xact({tag, "_pos"}, 1, 1'b0, {1'b1, a}, 3'b010,
                              $urandom_range(1, lat_max), 1'b0, -1);
        if (mask[0]) run_xact({tag, "_wr"}, 1, 1'b1, c, 3'b001,
                              $urandom_range(1, lat_max), 1'b0, -1);
    endtask

    initial begin
        logic [7:0] early_c;

        // Reset state
        reset = 1'b0;
        repeat (3) step();
        chk_all_zero("rst");

        // Power-up and init
        reset = 1'b1;
        run_init("pu");

        // Single write
        wr_char = 8'h41;
        wr_req  = 1'b1;
        run_xact("wr41", 1, 1'b1, 8'h41, 3'b001, 3, 1'b0, -1);

        // Priority: all three raised together
        pos_addr = 7'h40;
        wr_char  = 8'h5A;
        clr_req  = 1'b1;
        pos_req  = 1'b1;
        wr_req   = 1'b1;
        run_xact("pri_clr", 1, 1'b0, 8'h01, 3'b100, 2, 1'b0, -1);
        run_xact("pri_pos", 1, 1'b0, 8'hC0, 3'b010, 2, 1'b0, -1);
        run_xact("pri_wr",  1, 1'b1, 8'h5A, 3'b001, 2, 1'b0, -1);

        // Stray dataDone while idle
        dataDone = 1'b1;
        step();
        dataDone = 1'b0;
        repeat (2) step();
        chk("stray_busy",  32'(busy),      32'(0));
        chk("stray_ready", 32'(dataReady), 32'(0));

        // Stalled send FSM
        wr_char = 8'h33;
        wr_req  = 1'b1;
        run_xact("stall", 1, 1'b1, 8'h33, 3'b001, 50, 1'b0, -1);

        // Character 0x02 takes the long delay even as data
        wr_char = 8'h02;
        wr_req  = 1'b1;
        run_xact("wr02", 1, 1'b1, 8'h02, 3'b001, 1, 1'b0, -1);

        // Randomized request mixes
        for (int it = 0; it < 30; it++) begin
            host_batch($sformatf("rnd%0d", it), 3'($urandom_range(1, 7)), 6);
        end

        // Reset in the middle of a clear's delay, with a write raised early
        clr_req = 1'b1;
        run_xact("abort_clr", 1, 1'b0, 8'h01, 3'b100, 2, 1'b0, 4);
        reset = 1'b0;
        step();
        chk_all_zero("midrst");
        early_c = 8'($urandom_range(0, 255));
        wr_char = early_c;
        wr_req  = 1'b1;
        reset   = 1'b1;
        run_init("re");
        run_xact("early_wr", 1, 1'b1, early_c, 3'b001, 2, 1'b0, -1);

        finish_up();
    end

endmodule
